// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus: redirect/halt control, instruction-memory port, decode port.
// The master modport is the fetch unit's view; slave is the environment's.
interface fetch_queue_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_npc;
    logic              instr_ready;
    logic [CW-1:0]     q_count;

    modport master (
        input  redirect, redirect_pc, halt,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr,
        output instr_valid, instr, instr_pc, instr_npc, q_count
    );

    modport slave (
        output redirect, redirect_pc, halt,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr,
        input  instr_valid, instr, instr_pc, instr_npc, q_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: single-outstanding imem requests feeding a prefetch queue,
// with branch redirect/flush and halt.
module fetch_queue_unit #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter int              PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input logic                 clk,
    input logic                 rst,
    fetch_queue_unit_if.master  bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);
    localparam logic [CW-1:0]     QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [ADDR_W-1:0] out_q, out_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [QDEPTH];
    logic [ADDR_W-1:0] pcs_q [QDEPTH];

    logic req, grant, push, pop, head_v, ivalid;

    assign req = (state_q == ISSUE) && (cnt_q < QFULL)
              && !bus.halt && !bus.redirect && !rst;
    assign grant  = req && bus.imem_ready;
    assign head_v = (cnt_q != '0);
    assign ivalid = head_v && !bus.redirect && !rst;
    assign push   = (state_q == WAIT) && bus.imem_rvalid
                 && !bus.redirect;
    assign pop    = ivalid && bus.instr_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_q;
    assign bus.instr_valid = ivalid;
    assign bus.instr       = head_v ? mem_q[rd_q] : '0;
    assign bus.instr_pc    = head_v ? pcs_q[rd_q] : '0;
    assign bus.instr_npc   = bus.instr_pc + INC;
    assign bus.q_count     = cnt_q;

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        out_d   = out_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (bus.redirect) begin
            fetch_d = bus.redirect_pc;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            unique case (state_q)
                WAIT, DRAIN: state_d = bus.imem_rvalid ? ISSUE : DRAIN;
                default:     state_d = ISSUE;
            endcase
        end else begin
            unique case (state_q)
                ISSUE: if (grant) begin
                    out_d   = fetch_q;
                    fetch_d = fetch_q + INC;
                    state_d = WAIT;
                end
                WAIT, DRAIN: if (bus.imem_rvalid) state_d = ISSUE;
                default: state_d = ISSUE;
            endcase
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (push && !pop)      cnt_d = cnt_q + 1'b1;
            else if (pop && !push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE;
            fetch_q <= RESET_PC;
            out_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue payload needs no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= bus.imem_rdata;
            pcs_q[wr_q] <= out_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a cycle table for basic fetch and
// queue fill/drain, then hand-written redirect, halt, reset and wrap cases.
module tb_fetch_queue_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.DATA_W(16), .ADDR_W(16), .QDEPTH(4)) bus ();
    fetch_queue_unit_if #(.DATA_W(16), .ADDR_W(16), .QDEPTH(4)) bus2 ();

    fetch_queue_unit #(
        .DATA_W(16), .ADDR_W(16), .PC_INC(2),
        .RESET_PC(16'h0000), .QDEPTH(4)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    fetch_queue_unit #(
        .DATA_W(16), .ADDR_W(16), .PC_INC(2),
        .RESET_PC(16'hFFFC), .QDEPTH(4)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rdata;
        logic        irdy;
        logic        req;
        logic [15:0] addr;
        logic        iv;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic [15:0] npc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t v(
        input logic rdy, rv, input logic [15:0] rdata, input logic irdy,
        input logic req, input logic [15:0] addr, input logic iv,
        input logic [15:0] instr, ipc, npc, input logic [2:0] cnt);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rdata = rdata; r.irdy = irdy;
        r.req = req; r.addr = addr; r.iv = iv; r.instr = instr;
        r.ipc = ipc; r.npc = npc; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, rv, input logic [15:0] rd,
                         input logic irdy, hlt, red,
                         input logic [15:0] rpc);
        @(negedge clk);
        rst             = 1'b0;
        bus.imem_ready  = rdy;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.instr_ready = irdy;
        bus.halt        = hlt;
        bus.redirect    = red;
        bus.redirect_pc = rpc;
        #1;
    endtask

    task automatic drive2(input logic rdy, rv, input logic [15:0] rd,
                          input logic irdy);
        @(negedge clk);
        bus2.imem_ready  = rdy;
        bus2.imem_rvalid = rv;
        bus2.imem_rdata  = rd;
        bus2.instr_ready = irdy;
        #1;
    endtask

    task automatic set_rst();
        @(negedge clk);
        rst             = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.instr_ready = 1'b0;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        #1;
    endtask

    initial begin
        bus.redirect = 0; bus.redirect_pc = 0; bus.halt = 0;
        bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.instr_ready = 0;
        bus2.redirect = 0; bus2.redirect_pc = 0; bus2.halt = 0;
        bus2.imem_ready = 0; bus2.imem_rvalid = 0; bus2.imem_rdata = 0;
        bus2.instr_ready = 0;

        // rdy rv rdata irdy | req addr iv instr ipc npc cnt
        tbl[0]  = v(1,0,16'h0000,1, 1,16'h0000,0,16'h0000,16'h0000,16'h0002,0);
        tbl[1]  = v(1,1,16'hA000,1, 0,16'h0002,0,16'h0000,16'h0000,16'h0002,0);
        tbl[2]  = v(1,0,16'h0000,1, 1,16'h0002,1,16'hA000,16'h0000,16'h0002,1);
        tbl[3]  = v(1,1,16'hA002,1, 0,16'h0004,0,16'h0000,16'h0000,16'h0002,0);
        tbl[4]  = v(1,0,16'h0000,1, 1,16'h0004,1,16'hA002,16'h0002,16'h0004,1);
        tbl[5]  = v(1,1,16'hA004,0, 0,16'h0006,0,16'h0000,16'h0000,16'h0002,0);
        tbl[6]  = v(1,0,16'h0000,0, 1,16'h0006,1,16'hA004,16'h0004,16'h0006,1);
        tbl[7]  = v(1,1,16'hA006,0, 0,16'h0008,1,16'hA004,16'h0004,16'h0006,1);
        tbl[8]  = v(1,0,16'h0000,0, 1,16'h0008,1,16'hA004,16'h0004,16'h0006,2);
        tbl[9]  = v(1,1,16'hA008,0, 0,16'h000A,1,16'hA004,16'h0004,16'h0006,2);
        tbl[10] = v(1,0,16'h0000,0, 1,16'h000A,1,16'hA004,16'h0004,16'h0006,3);
        tbl[11] = v(1,1,16'hA00A,0, 0,16'h000C,1,16'hA004,16'h0004,16'h0006,3);
        tbl[12] = v(1,0,16'h0000,0, 0,16'h000C,1,16'hA004,16'h0004,16'h0006,4);
        tbl[13] = v(1,0,16'h0000,1, 0,16'h000C,1,16'hA004,16'h0004,16'h0006,4);
        tbl[14] = v(0,0,16'h0000,1, 1,16'h000C,1,16'hA006,16'h0006,16'h0008,3);
        tbl[15] = v(0,0,16'h0000,1, 1,16'h000C,1,16'hA008,16'h0008,16'h000A,2);
        tbl[16] = v(0,0,16'h0000,1, 1,16'h000C,1,16'hA00A,16'h000A,16'h000C,1);
        tbl[17] = v(1,0,16'h0000,1, 1,16'h000C,0,16'h0000,16'h0000,16'h0002,0);

        set_rst();
        chk("rst_req",   64'(bus.imem_req),    0);
        chk("rst_valid", 64'(bus.instr_valid), 0);
        chk("rst_instr", 64'(bus.instr),       0);
        chk("rst_pc",    64'(bus.instr_pc),    0);
        chk("rst_cnt",   64'(bus.q_count),     0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].irdy,
                  1'b0, 1'b0, 16'h0000);
            n_vec++;
            if (bus.imem_req !== tbl[i].req || bus.imem_addr !== tbl[i].addr
             || bus.instr_valid !== tbl[i].iv || bus.instr !== tbl[i].instr
             || bus.instr_pc !== tbl[i].ipc || bus.instr_npc !== tbl[i].npc
             || bus.q_count !== tbl[i].cnt) begin
                n_bad++;
                $display("FAIL vec[%0d]: got req=%0b addr=%h v=%0b i=%h pc=%h npc=%h c=%0d, want req=%0b addr=%h v=%0b i=%h pc=%h npc=%h c=%0d",
                    i, bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr,
                    bus.instr_pc, bus.instr_npc, bus.q_count,
                    tbl[i].req, tbl[i].addr, tbl[i].iv, tbl[i].instr,
                    tbl[i].ipc, tbl[i].npc, tbl[i].cnt);
            end
        end

        // Request to 0x000C outstanding; redirect twice, late rvalid dropped.
        drive(1,0,16'h0,1,0,0,16'h0);
        chk("s1_req",  64'(bus.imem_req),  0);
        chk("s1_addr", 64'(bus.imem_addr), 16'h000E);
        drive(1,0,16'h0,1,0,1,16'h0100);
        chk("redir_req",   64'(bus.imem_req),    0);
        chk("redir_valid", 64'(bus.instr_valid), 0);
        drive(1,0,16'h0,1,0,1,16'h0200);
        chk("drain_req",  64'(bus.imem_req),  0);
        chk("drain_addr", 64'(bus.imem_addr), 16'h0100);
        chk("drain_cnt",  64'(bus.q_count),   0);
        drive(1,1,16'hA00C,1,0,0,16'h0);
        chk("drop_valid", 64'(bus.instr_valid), 0);
        chk("drop_req",   64'(bus.imem_req),    0);
        chk("drop_addr",  64'(bus.imem_addr),   16'h0200);
        drive(1,0,16'h0,1,0,0,16'h0);
        chk("post_valid", 64'(bus.instr_valid), 0);
        chk("post_cnt",   64'(bus.q_count),     0);
        chk("post_req",   64'(bus.imem_req),    1);
        chk("post_addr",  64'(bus.imem_addr),   16'h0200);

        // Redirect coinciding with rvalid and a pending pop.
        drive(1,1,16'hB200,0,0,0,16'h0);
        chk("s6_addr", 64'(bus.imem_addr), 16'h0202);
        drive(1,0,16'h0,0,0,0,16'h0);
        chk("s7_valid", 64'(bus.instr_valid), 1);
        chk("s7_instr", 64'(bus.instr),       16'hB200);
        chk("s7_pc",    64'(bus.instr_pc),    16'h0200);
        chk("s7_npc",   64'(bus.instr_npc),   16'h0202);
        chk("s7_req",   64'(bus.imem_req),    1);
        drive(1,1,16'hB202,1,0,1,16'h0300);
        chk("rvr_valid", 64'(bus.instr_valid), 0);
        chk("rvr_req",   64'(bus.imem_req),    0);
        drive(0,0,16'h0,1,0,0,16'h0);
        chk("rvr_cnt",   64'(bus.q_count),     0);
        chk("rvr_valid2",64'(bus.instr_valid), 0);
        chk("rvr_req2",  64'(bus.imem_req),    1);
        chk("rvr_addr",  64'(bus.imem_addr),   16'h0300);
        drive(0,0,16'h0,1,0,0,16'h0);
        chk("hold_req",  64'(bus.imem_req),  1);
        chk("hold_addr", 64'(bus.imem_addr), 16'h0300);
        drive(1,0,16'h0,1,0,0,16'h0);

        // Halt while WAIT: response still queued, no new request.
        drive(1,0,16'h0,0,1,0,16'h0);
        chk("halt_w_req", 64'(bus.imem_req), 0);
        drive(1,1,16'hB300,0,1,0,16'h0);
        drive(1,0,16'h0,0,1,0,16'h0);
        chk("halt_req",   64'(bus.imem_req), 0);
        chk("halt_cnt",   64'(bus.q_count),  1);
        chk("halt_instr", 64'(bus.instr),    16'hB300);
        chk("halt_pc",    64'(bus.instr_pc), 16'h0300);
        drive(1,0,16'h0,1,1,0,16'h0);
        chk("halt_pop_req", 64'(bus.imem_req), 0);
        drive(1,0,16'h0,1,0,0,16'h0);
        chk("resume_cnt",  64'(bus.q_count),   0);
        chk("resume_req",  64'(bus.imem_req),  1);
        chk("resume_addr", 64'(bus.imem_addr), 16'h0302);

        // Reset mid-WAIT, then a stale rvalid.
        set_rst();
        chk("mrst_req",   64'(bus.imem_req),    0);
        chk("mrst_valid", 64'(bus.instr_valid), 0);
        drive(0,1,16'hDEAD,1,0,0,16'h0);
        chk("stale_req",  64'(bus.imem_req),  1);
        chk("stale_addr", 64'(bus.imem_addr), 16'h0000);
        drive(0,0,16'h0,1,0,0,16'h0);
        chk("stale_cnt",   64'(bus.q_count),     0);
        chk("stale_valid", 64'(bus.instr_valid), 0);

        // PC wrap with RESET_PC = 0xFFFC.
        drive2(1,0,16'h0,1);
        chk("w0_req",  64'(bus2.imem_req),  1);
        chk("w0_addr", 64'(bus2.imem_addr), 16'hFFFC);
        drive2(1,1,16'hC0FC,1);
        chk("w1_addr", 64'(bus2.imem_addr), 16'hFFFE);
        chk("w1_req",  64'(bus2.imem_req),  0);
        drive2(1,0,16'h0,1);
        chk("w2_valid", 64'(bus2.instr_valid), 1);
        chk("w2_instr", 64'(bus2.instr),       16'hC0FC);
        chk("w2_pc",    64'(bus2.instr_pc),    16'hFFFC);
        chk("w2_npc",   64'(bus2.instr_npc),   16'hFFFE);
        chk("w2_addr",  64'(bus2.imem_addr),   16'hFFFE);
        drive2(1,1,16'hC0FE,1);
        chk("w3_addr", 64'(bus2.imem_addr), 16'h0000);
        drive2(1,0,16'h0,1);
        chk("w4_instr", 64'(bus2.instr),     16'hC0FE);
        chk("w4_pc",    64'(bus2.instr_pc),  16'hFFFE);
        chk("w4_npc",   64'(bus2.instr_npc), 16'h0000);
        chk("w4_addr",  64'(bus2.imem_addr), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised fetch stage for the WISC pipeline. Generalises the fixed 16-bit, PC+2 fetch with a configurable width, increment and reset vector.
- Adds a variable-latency instruction-memory handshake, a prefetch instruction queue, branch redirect with flush, and halt.
- Sits between PC/branch logic and decode. Presents {instr, pc, next-pc} to decode through a valid/ready handshake.

Parameters:
- DATA_W, 16: instruction width.
- ADDR_W, 16: PC/address width.
- PC_INC, 2: byte increment per instruction.
- RESET_PC, 0: PC after reset.
- QDEPTH, 4: instruction queue entries. Must be a power of 2 and ≥2.

Ports:
- clk, in, 1: clock, all state on posedge.
- rst, in, 1: synchronous active-high reset.
- redirect, in, 1: branch/jump taken; flushes the queue.
- redirect_pc, in, ADDR_W: new fetch target.
- halt, in, 1: level signal; blocks new memory requests.
- imem_req, out, 1: fetch request.
- imem_addr, out, ADDR_W: request address, equal to fetch_pc.
- imem_ready, in, 1: memory accepts the request this cycle.
- imem_rvalid, in, 1: read data valid.
- imem_rdata, in, DATA_W: read data.
- instr_valid, out, 1: queue head valid.
- instr, out, DATA_W: head instruction.
- instr_pc, out, ADDR_W: head instruction address.
- instr_npc, out, ADDR_W: instr_pc+PC_INC, mod 2^ADDR_W.
- instr_ready, in, 1: decode consumes the head.
- q_count, out, clog2(QDEPTH)+1: number of occupied entries.

Behaviour:
- Reset (sync):
  - fetch_pc=RESET_PC, state=ISSUE, q_count=0, rd/wr pointers=0, drop=0.
  - Outputs: imem_req=0, instr_valid=0, instr/instr_pc=0 (storage may hold X but outputs are forced to 0 when empty).
- States: ISSUE (nothing outstanding), WAIT (one outstanding, keep the response), DRAIN (one outstanding, discard the response). At most one request is outstanding.
- imem_req = (state==ISSUE) & (q_count<QDEPTH) & ~halt & ~redirect. Combinational.
- Issue: imem_req & imem_ready → latch out_pc=fetch_pc, fetch_pc += PC_INC (wraps 0xFFFE→0x0000 at defaults), go to WAIT. If imem_ready=0, hold the request and address.
- WAIT & imem_rvalid:
  - Push {imem_rdata, out_pc} at wr_ptr; wr_ptr++ mod QDEPTH.
  - Go to ISSUE. The next issue may happen in that same cycle only if it is already ISSUE, so a new request comes the cycle after.
- DRAIN & imem_rvalid: discard the data, go to ISSUE.
- imem_rvalid while in ISSUE (stale response): ignored.
- Latency:
  - Grant at cycle t, rvalid at t+k (k≥1), instr_valid at t+k+1.
  - Peak throughput is 1 instruction per 2 cycles.
- Queue:
  - instr_valid = (q_count!=0) & ~redirect.
  - Pop on instr_valid & instr_ready; rd_ptr++ mod QDEPTH.
  - Push and pop in the same cycle leave q_count unchanged.
  - Never overflows: an issue requires q_count<QDEPTH, and only one request is in flight.
- Redirect (highest priority, same cycle):
  - Flush: q_count=0, pointers=0.
  - fetch_pc=redirect_pc.
  - No pop or push takes effect that cycle.
  - If in WAIT without rvalid this cycle, go to DRAIN.
  - If in WAIT/DRAIN with rvalid this cycle, discard and go to ISSUE.
  - If in ISSUE, stay in ISSUE. imem_req=0 that cycle, so the first request to redirect_pc is the next cycle.
- Redirect while in DRAIN: stay in DRAIN, fetch_pc updated to the newest redirect_pc.
- Halt:
  - Suppresses new requests only. An outstanding response still completes; in WAIT it is queued.
  - The queue still drains to decode.
  - On deassert, fetch resumes at fetch_pc.
- Reset mid-operation: an outstanding request is abandoned with no drop; any later rvalid in ISSUE is ignored.

Test Plan:
- Reset then 1-cycle memory (ready=1, rvalid one cycle after grant), instr_ready=1 → imem_addr 0x0000, 0x0002, 0x0004…; instr_pc/instr_npc 0x0000/0x0002 first; instr matches memory.
- instr_ready=0 with 1-cycle memory → q_count reaches 4 and imem_req drops to 0. Raise instr_ready → 4 pops in order, then fetch resumes at 0x0008.
- Request to 0x0010 in flight with rvalid delayed 3 cycles; redirect=1, redirect_pc=0x0100 → state DRAIN, q_count=0, the 0x0010 data is never visible, next imem_addr=0x0100.
- Redirect in the same cycle as rvalid and a pending pop → response dropped, no pop counted, q_count=0, instr_valid=0 that cycle.
- RESET_PC=0xFFFC → addresses 0xFFFC, 0xFFFE, 0x0000; instr_npc at 0xFFFE is 0x0000.
- halt=1 while WAIT → response still queued, no further imem_req. halt=0 → next request at the following PC. rst mid-WAIT → fetch_pc=RESET_PC, a stale rvalid is ignored.
